uart_tx_fifo: RTL and testbench

Byte FIFO that buffers console output ahead of the UART transmitter. Producers (the MMIO console register write path) push bytes at core speed; the FIFO presents them in order on a valid/ready interface that connects directly to the transmitter's `i_data`/`i_valid`/`o_ready`. Pushes that arrive while the FIFO is full are dropped and recorded in a sticky overflow flag, so stores are never stalled.

---
 rtl/uart_tx_fifo.sv | 82 ++++++++
 tb/tb_uart_tx_fifo.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_tx_fifo : byte FIFO between the console write path and the UART TX.
//                Pushes while full are dropped and latch a sticky overflow.
// Revision     : 1.0
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_wr_valid,
  input  logic [DATA_WIDTH-1:0]      i_wr_data,
  output logic                       o_wr_ready,
  output logic [DATA_WIDTH-1:0]      o_data,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_empty,
  output logic                       o_full,
  output logic                       o_overflow,
  input  logic                       i_clr_overflow
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]       count_q,  count_d;
  logic                  overflow_q, overflow_d;
  logic                  full, empty, do_push, do_pop, do_drop;

  // Status comes only from the registered count, so i_ready never reaches o_wr_ready.
  assign full    = (count_q == (ADDR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = i_wr_valid && !full;
  assign do_drop = i_wr_valid && full;
  assign do_pop  = !empty && i_ready;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (do_push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    if (do_push && !do_pop)      count_d = count_q + (ADDR_W+1)'(1);
    else if (do_pop && !do_push) count_d = count_q - (ADDR_W+1)'(1);
    if (do_drop)             overflow_d = 1'b1;
    else if (i_clr_overflow) overflow_d = 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_wr_data;
  end

  assign o_data     = mem_q[rd_ptr_q];
  assign o_valid    = !empty;
  assign o_empty    = empty;
  assign o_full     = full;
  assign o_wr_ready = !full;
  assign o_count    = count_q;
  assign o_overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// Scoreboard bench for uart_tx_fifo with a one-clock-per-bit transmitter model.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic [4:0] count;
  logic       empty, full, overflow;
  logic       clr_overflow;

  logic       stim_ready;
  logic       use_tx;
  logic       tx_ready;
  logic       tx_line;
  logic [9:0] tx_sh;
  int         tx_bits;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];

  assign ready = use_tx ? tx_ready : stim_ready;

  uart_tx_fifo #(.DATA_WIDTH(8), .DEPTH(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_wr_valid(wr_valid), .i_wr_data(wr_data),
    .o_wr_ready(wr_ready), .o_data(data), .o_valid(valid), .i_ready(ready),
    .o_count(count), .o_empty(empty), .o_full(full), .o_overflow(overflow),
    .i_clr_overflow(clr_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input bit accepted);
    wr_valid = 1'b1;
    wr_data  = d;
    if (accepted) exp_q.push_back(d);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    stim_ready = 1'b1;
    while (!empty && n < 64) begin
      tick();
      n++;
    end
    stim_ready = 1'b0;
    check("drain_empty", empty, 1);
  endtask

  // Monitor: a pop happens at the next rising edge whenever valid && ready now.
  always @(negedge clk) begin
    if (!rst && valid && ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL pop_data: actual=0x%0h required=<none expected>", data);
      end else begin
        check("pop_data", data, exp_q.pop_front());
      end
    end
  end

  // Transmitter model: 8N1 frames, one clock per bit, ready one cycle ahead of capture.
  always @(posedge clk) begin
    if (!use_tx) begin
      tx_ready <= 1'b0;
      tx_bits  <= 0;
      tx_line  <= 1'b1;
    end else if (tx_bits == 0) begin
      tx_line <= 1'b1;
      if (tx_ready && valid) begin
        tx_sh    <= {1'b1, data, 1'b0};
        tx_bits  <= 10;
        tx_ready <= 1'b0;
      end else begin
        tx_ready <= 1'b1;
      end
    end else begin
      tx_line <= tx_sh[0];
      if (tx_bits == 2) tx_ready <= 1'b1;
      if (tx_bits == 1 && tx_ready && valid) begin
        tx_sh    <= {1'b1, data, 1'b0};
        tx_bits  <= 10;
        tx_ready <= 1'b0;
      end else begin
        tx_sh   <= tx_sh >> 1;
        tx_bits <= tx_bits - 1;
      end
    end
  end

  initial begin
    logic rx[$];
    logic [7:0] b0, b1;
    int k;
    rst = 1'b1; wr_valid = 1'b0; wr_data = '0; stim_ready = 1'b0;
    clr_overflow = 1'b0; use_tx = 1'b0;
    #1;
    check("rst_valid", valid, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_overflow", overflow, 0);
    #1 rst = 1'b0;
    tick();

    // In-order drain with one-cycle visibility
    push(8'h41, 1);
    check("latency_valid", valid, 1);
    check("latency_data", data, 8'h41);
    push(8'h42, 1);
    push(8'h43, 1);
    check("three_count", count, 3);
    check("three_head", data, 8'h41);
    drain();

    // Fill, drop, drain
    for (int i = 0; i < 16; i++) push(8'(i), 1);
    check("fill_full", full, 1);
    check("fill_wr_ready", wr_ready, 0);
    push(8'hFF, 0);
    check("drop_overflow", overflow, 1);
    check("drop_count", count, 16);
    clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
    check("clr_overflow", overflow, 0);
    drain();

    // Pointer wrap
    for (int i = 0; i < 10; i++) push(8'h10 + 8'(i), 1);
    drain();
    for (int i = 0; i < 10; i++) push(8'h80 + 8'(i), 1);
    check("wrap_count", count, 10);
    drain();
    check("wrap_count_zero", count, 0);

    // Simultaneous push and pop at count 5
    for (int i = 0; i < 5; i++) push(8'h50 + 8'(i), 1);
    stim_ready = 1'b1;
    push(8'h55, 1);
    stim_ready = 1'b0;
    check("simul_count5", count, 5);
    drain();

    // Push and pop at full: push dropped
    for (int i = 0; i < 16; i++) push(8'h60 + 8'(i), 1);
    stim_ready = 1'b1;
    push(8'h77, 0);
    stim_ready = 1'b0;
    check("full_pop_count", count, 15);
    check("full_pop_overflow", overflow, 1);
    push(8'h70, 1);
    clr_overflow = 1'b1;
    push(8'h71, 0);
    clr_overflow = 1'b0;
    check("set_beats_clear", overflow, 1);
    clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
    check("clear_after", overflow, 0);
    drain();

    // Asynchronous reset mid-cycle
    for (int i = 0; i < 7; i++) push(8'hA0 + 8'(i), 1);
    check("pre_rst_count", count, 7);
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    check("async_valid", valid, 0);
    check("async_empty", empty, 1);
    check("async_count", count, 0);
    check("async_full", full, 0);
    check("async_wr_ready", wr_ready, 1);
    @(negedge clk) rst = 1'b0;
    tick();

    // End-to-end: "Hi" through the transmitter model
    use_tx = 1'b1;
    tick(); tick();
    push(8'h48, 1);
    push(8'h69, 1);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      rx.push_back(tx_line);
    end
    k = -1;
    for (int i = 0; i < 32; i++) if (k < 0 && rx[i] === 1'b0) k = i;
    if (k < 0 || k > 12) begin
      check("tx_start_found", 0, 1);
    end else begin
      for (int i = 0; i < 8; i++) begin
        b0[i] = rx[k + 1 + i];
        b1[i] = rx[k + 11 + i];
      end
      check("tx_frame0", b0, 8'h48);
      check("tx_stop0", rx[k + 9], 1);
      check("tx_start1_b2b", rx[k + 10], 0);
      check("tx_frame1", b1, 8'h69);
      check("tx_stop1", rx[k + 19], 1);
    end
    check("tx_fifo_empty", empty, 1);
    use_tx = 1'b0;
    tick();

    check("scoreboard_leftover", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
